worley_point_scheduler: RTL
===========================

Name: worley_point_scheduler

Overview:
- Owns the feature-point set consumed by the Worley noise datapath.
- Once per frame, during vertical blanking, steps every point by its signed velocity and bounces it off the screen edges.
- Provides an indexed read port so the distance datapath can fetch point coordinates.
- Provides a write port so a host or test FSM can load point positions and velocities between frame updates.

Parameters:
- NUM_POINTS, 4, number of feature points (2..16).
- COORD_W, 10, unsigned coordinate width.
- VEL_W, 4, signed two's-complement velocity width.
- X_MAX, 639, largest legal x coordinate.
- Y_MAX, 479, largest legal y coordinate.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- frame_tick  in  1  one-cycle pulse at start of vertical blanking
- pause  in  1  when high, frame_tick is ignored
- wr_en  in  1  write request
- wr_idx  in  4  point index to write
- wr_x  in  COORD_W  new x
- wr_y  in  COORD_W  new y
- wr_dx  in  VEL_W  new x velocity
- wr_dy  in  VEL_W  new y velocity
- wr_ready  out  1  write accepted this cycle when wr_en is also high
- rd_idx  in  4  read index
- rd_x  out  COORD_W  x of point rd_idx (combinational)
- rd_y  out  COORD_W  y of point rd_idx (combinational)
- busy  out  1  update sequence in progress
- overrun  out  1  sticky: frame_tick arrived while busy
- frame_count  out  16  completed update sequences

Behaviour:
- Reset, synchronous on clk while rst_n=0:
  - state=IDLE, busy=0, overrun=0, frame_count=0.
  - Point i: x=100+128*i mod (X_MAX+1), y=80+96*i mod (Y_MAX+1).
  - dx=+1 for even i, -1 for odd i; dy=+1 for all i.
- Reset mid-update abandons the sequence. Points already stepped are also reloaded to their reset values.
- FSM states: IDLE, UPDATE, DONE.
  - IDLE -> UPDATE on frame_tick=1 and pause=0; idx=0.
  - UPDATE: one point per cycle, idx 0..NUM_POINTS-1. After the last index -> DONE.
  - DONE: one cycle; frame_count increments (wraps at 16'hFFFF -> 0); -> IDLE.
  - A sequence therefore takes NUM_POINTS+1 cycles.
- busy=1 in UPDATE and DONE.
- frame_tick while busy: ignored, overrun set to 1. overrun clears only on reset.
- Per-axis step, computed as signed COORD_W+2 bits: n = p + sext(v).
  - n < 0: p=0, v=-v.
  - n > MAX: p=MAX, v=-v.
  - otherwise: p=n.
  - Negating the most negative velocity (-8 at VEL_W=4) saturates to +7.
  - x and y are stepped independently in the same cycle.
- Updated coordinates appear on the read port the cycle after that point's UPDATE cycle.
- Write handshake:
  - wr_ready = (state==IDLE) && !(frame_tick && !pause), combinational.
  - A write occurs when wr_en && wr_ready; registers update on that clock edge.
  - Writer holds wr_en and data until wr_ready.
  - frame_tick wins over a same-cycle write; that write is not accepted.
  - wr_idx >= NUM_POINTS: accepted, no effect.
  - Written coordinates above MAX are clamped to MAX.
- Read port: rd_idx >= NUM_POINTS returns 0 on both rd_x and rd_y.

Optional Feature:
- Macro: WORLEY_SCHED_JITTER_EN.
- Defined:
  - A 16-bit Galois LFSR (taps 16,14,13,11, seed 16'hACE1 at reset) advances one step per UPDATE cycle.
  - On any bounce, the reflected velocity's magnitude is replaced by {LFSR[1:0]}+1, i.e. 1..4, with the reflected sign kept.
- Undefined: pure reflection as above; no LFSR logic is present.

Test Plan:
- Reset, then read all indices -> point1 = (228,176), point3 = (484,368), rd_idx=5 returns (0,0); busy=0, frame_count=0.
- Single frame_tick -> busy high for exactly 5 cycles; point0 = (101,81), point1 = (227,177); frame_count=1.
- Bounce:
  - Write point2 x=638, dx=+3, y=1, dy=-4, then frame_tick -> x=639, dx=-3, y=0, dy=+4.
  - Write dx=-8 at x=2, then frame_tick -> x=0, dx=+7.
- Contention:
  - frame_tick and wr_en in the same IDLE cycle -> wr_ready=0, no write; write completes on the first cycle after DONE.
  - Second frame_tick during UPDATE -> overrun=1, only one sequence runs, frame_count increments by 1.
- pause=1 with 3 frame_ticks -> no point change, frame_count unchanged, wr_ready stays high.
- Reset asserted in UPDATE at idx=2 -> next cycle: state IDLE, all points at reset values, overrun=0.

Source files
------------

// File: rtl/worley_point_scheduler.sv
// Feature-point store for the Worley datapath: per-frame bounce update,
// indexed read port and host write port. Option: WORLEY_SCHED_JITTER_EN.
module worley_point_scheduler #(
   parameter int NUM_POINTS = 4,
   parameter int COORD_W    = 10,
   parameter int VEL_W      = 4,
   parameter int X_MAX      = 639,
   parameter int Y_MAX      = 479
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_tick,
   input  logic               pause,
   input  logic               wr_en,
   input  logic [3:0]         wr_idx,
   input  logic [COORD_W-1:0] wr_x,
   input  logic [COORD_W-1:0] wr_y,
   input  logic [VEL_W-1:0]   wr_dx,
   input  logic [VEL_W-1:0]   wr_dy,
   output logic               wr_ready,
   input  logic [3:0]         rd_idx,
   output logic [COORD_W-1:0] rd_x,
   output logic [COORD_W-1:0] rd_y,
   output logic               busy,
   output logic               overrun,
   output logic [15:0]        frame_count
);

   typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

   localparam logic [COORD_W-1:0] XLIM = COORD_W'(X_MAX);
   localparam logic [COORD_W-1:0] YLIM = COORD_W'(Y_MAX);
   localparam logic [3:0]         LAST = 4'(NUM_POINTS - 1);

   state_t state_q, state_d;
   logic [3:0]         idx_q;
   logic               overrun_q;
   logic [15:0]        frame_count_q;

   logic [COORD_W-1:0] px_q [NUM_POINTS];
   logic [COORD_W-1:0] py_q [NUM_POINTS];
   logic [VEL_W-1:0]   vx_q [NUM_POINTS];
   logic [VEL_W-1:0]   vy_q [NUM_POINTS];

   logic               tick_go;
   logic               wr_fire;
   logic [COORD_W-1:0] cur_x, cur_y;
   logic [VEL_W-1:0]   cur_vx, cur_vy;
   logic [COORD_W-1:0] nx, ny;
   logic [VEL_W-1:0]   nvx, nvy;
   logic [VEL_W-1:0]   rvx, rvy;
   logic               bx, by;
   logic [COORD_W-1:0] wx_clamp, wy_clamp;

   // Returns {bounced, new_position}; sum is formed wide enough to
   // see both underflow below zero and overflow past the limit.
   function automatic logic [COORD_W:0] step_pos(
      input logic [COORD_W-1:0] p,
      input logic [VEL_W-1:0]   v,
      input logic [COORD_W-1:0] lim
   );
      logic signed [COORD_W+1:0] n;
      n = $signed({2'b00, p}) +
          $signed({{(COORD_W+2-VEL_W){v[VEL_W-1]}}, v});
      if (n < 0)
         return {1'b1, {COORD_W{1'b0}}};
      if (n > $signed({2'b00, lim}))
         return {1'b1, lim};
      return {1'b0, n[COORD_W-1:0]};
   endfunction

   function automatic logic [VEL_W-1:0] reflect(
      input logic [VEL_W-1:0] v
   );
      if (v == {1'b1, {(VEL_W-1){1'b0}}})
         return {1'b0, {(VEL_W-1){1'b1}}};
      return -v;
   endfunction

`ifdef WORLEY_SCHED_JITTER_EN
   logic [15:0] lfsr_q;

   function automatic logic [VEL_W-1:0] jitter(
      input logic [VEL_W-1:0] v,
      input logic [1:0]       j
   );
      logic [VEL_W-1:0] mag;
      mag = VEL_W'(j) + VEL_W'(1);
      return v[VEL_W-1] ? -mag : mag;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n)
         lfsr_q <= 16'hACE1;
      else if (state_q == UPDATE)
         lfsr_q <= {1'b0, lfsr_q[15:1]} ^
                   (lfsr_q[0] ? 16'hB400 : 16'h0000);
   end
`endif

   assign tick_go  = frame_tick && !pause;
   assign wr_ready = (state_q == IDLE) && !tick_go;
   assign wr_fire  = wr_en && wr_ready;
   assign busy     = (state_q != IDLE);
   assign overrun  = overrun_q;
   assign frame_count = frame_count_q;

   assign wx_clamp = (wr_x > XLIM) ? XLIM : wr_x;
   assign wy_clamp = (wr_y > YLIM) ? YLIM : wr_y;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (tick_go) state_d = UPDATE;
         UPDATE:  if (idx_q == LAST) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cur_x  = '0;
      cur_y  = '0;
      cur_vx = '0;
      cur_vy = '0;
      for (int i = 0; i < NUM_POINTS; i++) begin
         if (idx_q == 4'(i)) begin
            cur_x  = px_q[i];
            cur_y  = py_q[i];
            cur_vx = vx_q[i];
            cur_vy = vy_q[i];
         end
      end
   end

   always_comb begin
      rd_x = '0;
      rd_y = '0;
      for (int i = 0; i < NUM_POINTS; i++) begin
         if (rd_idx == 4'(i)) begin
            rd_x = px_q[i];
            rd_y = py_q[i];
         end
      end
   end

   always_comb begin
      {bx, nx} = step_pos(cur_x, cur_vx, XLIM);
      {by, ny} = step_pos(cur_y, cur_vy, YLIM);
      rvx = reflect(cur_vx);
      rvy = reflect(cur_vy);
`ifdef WORLEY_SCHED_JITTER_EN
      rvx = jitter(rvx, lfsr_q[1:0]);
      rvy = jitter(rvy, lfsr_q[1:0]);
`endif
      nvx = bx ? rvx : cur_vx;
      nvy = by ? rvy : cur_vy;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         overrun_q     <= 1'b0;
         frame_count_q <= '0;
         for (int i = 0; i < NUM_POINTS; i++) begin
            px_q[i] <= COORD_W'((100 + 128 * i) % (X_MAX + 1));
            py_q[i] <= COORD_W'((80 + 96 * i) % (Y_MAX + 1));
            vx_q[i] <= (i % 2 == 0) ? VEL_W'(1) : '1;
            vy_q[i] <= VEL_W'(1);
         end
      end else begin
         state_q <= state_d;
         if (busy && tick_go)
            overrun_q <= 1'b1;
         unique case (state_q)
            IDLE:    idx_q <= '0;
            UPDATE:  idx_q <= idx_q + 4'd1;
            DONE:    frame_count_q <= frame_count_q + 16'd1;
            default: idx_q <= '0;
         endcase
         for (int i = 0; i < NUM_POINTS; i++) begin
            if (state_q == UPDATE && idx_q == 4'(i)) begin
               px_q[i] <= nx;
               py_q[i] <= ny;
               vx_q[i] <= nvx;
               vy_q[i] <= nvy;
            end else if (wr_fire && wr_idx == 4'(i)) begin
               px_q[i] <= wx_clamp;
               py_q[i] <= wy_clamp;
               vx_q[i] <= wr_dx;
               vy_q[i] <= wr_dy;
            end
         end
      end
   end

endmodule
